// File: rtl/monitor_stage_pkg.sv
// Shared defaults, report entry type and FIFO state helper
// for the monitor stage pipeline.
package monitor_stage_pkg;

    localparam int DEF_SYM_W      = 8;
    localparam int DEF_NUM_CH     = 40;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_CNT_W      = 32;
    localparam int DROP_W         = 16;

    typedef struct packed {
        logic [DEF_CNT_W-1:0]  cycle;
        logic [DEF_NUM_CH-1:0] vec;
    } rpt_entry_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_t;

    function automatic fifo_state_t fifo_state(input logic empty,
                                               input logic full);
        if (empty)     return FIFO_EMPTY;
        else if (full) return FIFO_FULL;
        else           return FIFO_PARTIAL;
    endfunction

endpackage

// File: rtl/monitor_stage_pipe_fifo.sv
// Synchronous report FIFO: show-ahead read, push and pop may
// coincide (also when full), pop on empty is ignored.
module monitor_report_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset since the head is
    // only meaningful while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally modulo DEPTH; occupancy tracks both.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop_ok)
                count <= count + CNT_W'(1);
            else if (pop_ok && !push_ok)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/monitor_stage_pipe.sv
// Monitor stage: forwards symbol/run/reset to the next stage and
// queues time-stamped automaton reports for a downstream consumer.
module monitor_stage_pipe
    import monitor_stage_pkg::*;
#(
    parameter int SYM_W      = DEF_SYM_W,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [SYM_W-1:0]  top_symbols,
    input  logic [NUM_CH-1:0] rpt_in,
    input  logic              sticky_clr,
    output logic [SYM_W-1:0]  out_symbols,
    output logic              out_reset,
    output logic              out_run,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [CNT_W-1:0]  rpt_cycle,
    output logic [NUM_CH-1:0] rpt_vec,
    output logic [NUM_CH-1:0] rpt_sticky,
    output logic              rpt_overflow,
    output logic [DROP_W-1:0] rpt_drop_cnt
);

    localparam int EW = CNT_W + NUM_CH;

    logic [CNT_W-1:0] cycle_cnt;
    logic             capture;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [EW-1:0]    head;
    fifo_state_t      fstate;

    assign capture   = run && (|rpt_in);
    assign pop       = rpt_valid && rpt_ready;
    assign drop      = capture && fifo_full && !pop;
    assign fstate    = fifo_state(fifo_empty, fifo_full);
    assign rpt_valid = (fstate != FIFO_EMPTY);
    assign rpt_cycle = head[EW-1:NUM_CH];
    assign rpt_vec   = head[NUM_CH-1:0];

    monitor_report_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (capture),
        .pop   (pop),
        .wdata ({cycle_cnt, rpt_in}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-stage pipeline register; symbol only advances with run.
    always_ff @(posedge clk) begin
        out_reset <= reset;
        if (reset) begin
            out_symbols <= '0;
            out_run     <= 1'b0;
        end else begin
            out_run <= run;
            if (run)
                out_symbols <= top_symbols;
        end
    end

    // Cycle stamp counter, wraps freely, frozen while run is low.
    always_ff @(posedge clk) begin
        if (reset)
            cycle_cnt <= '0;
        else if (run)
            cycle_cnt <= cycle_cnt + CNT_W'(1);
    end

    // Sticky report OR; new bits win over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset)
            rpt_sticky <= '0;
        else if (sticky_clr)
            rpt_sticky <= run ? rpt_in : '0;
        else if (run)
            rpt_sticky <= rpt_sticky | rpt_in;
    end

    // Overflow flag and saturating drop count; a drop wins over clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_overflow <= 1'b0;
            rpt_drop_cnt <= '0;
        end else if (sticky_clr) begin
            rpt_overflow <= drop;
            rpt_drop_cnt <= drop ? DROP_W'(1) : '0;
        end else if (drop) begin
            rpt_overflow <= 1'b1;
            if (rpt_drop_cnt != '1)
                rpt_drop_cnt <= rpt_drop_cnt + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_monitor_stage_pipe.sv
// Directed bench for monitor_stage_pipe with a report scoreboard.
module tb_monitor_stage_pipe;
    import monitor_stage_pkg::*;

    localparam int DEPTH = DEF_FIFO_DEPTH;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  run;
    logic [DEF_SYM_W-1:0]  top_symbols;
    logic [DEF_NUM_CH-1:0] rpt_in;
    logic                  sticky_clr;
    logic [DEF_SYM_W-1:0]  out_symbols;
    logic                  out_reset;
    logic                  out_run;
    logic                  rpt_valid;
    logic                  rpt_ready;
    logic [DEF_CNT_W-1:0]  rpt_cycle;
    logic [DEF_NUM_CH-1:0] rpt_vec;
    logic [DEF_NUM_CH-1:0] rpt_sticky;
    logic                  rpt_overflow;
    logic [DROP_W-1:0]     rpt_drop_cnt;

    int checks = 0;
    int errors = 0;

    rpt_entry_t           sbq[$];
    logic [DEF_CNT_W-1:0] cnt_m;

    always #5 clk = ~clk;

    monitor_stage_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .top_symbols  (top_symbols),
        .rpt_in       (rpt_in),
        .sticky_clr   (sticky_clr),
        .out_symbols  (out_symbols),
        .out_reset    (out_reset),
        .out_run      (out_run),
        .rpt_valid    (rpt_valid),
        .rpt_ready    (rpt_ready),
        .rpt_cycle    (rpt_cycle),
        .rpt_vec      (rpt_vec),
        .rpt_sticky   (rpt_sticky),
        .rpt_overflow (rpt_overflow),
        .rpt_drop_cnt (rpt_drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare head against scoreboard, update model, advance a cycle.
    task automatic tick();
        rpt_entry_t e;
        chk("rpt_valid", 64'(rpt_valid), 64'(sbq.size() != 0));
        if (rpt_valid && rpt_ready && sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("rpt_cycle", 64'(rpt_cycle), 64'(e.cycle));
            chk("rpt_vec", 64'(rpt_vec), 64'(e.vec));
        end
        if (!reset && run && (rpt_in != '0) && sbq.size() < DEPTH) begin
            e.cycle = cnt_m;
            e.vec   = rpt_in;
            sbq.push_back(e);
        end
        if (reset) begin
            sbq.delete();
            cnt_m = '0;
        end else if (run) begin
            cnt_m = cnt_m + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b0;
        top_symbols = '0;
        rpt_in      = '0;
        sticky_clr  = 1'b0;
        rpt_ready   = 1'b0;
        cnt_m       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_reset", 64'(out_reset), 64'd1);
        chk("reset_out_sym", 64'(out_symbols), 64'd0);
        chk("reset_out_run", 64'(out_run), 64'd0);
        chk("reset_sticky", 64'(rpt_sticky), 64'd0);
        chk("reset_ovf", 64'(rpt_overflow), 64'd0);
        chk("reset_drop", 64'(rpt_drop_cnt), 64'd0);
        reset = 1'b0;
        tick();
        chk("out_reset_low", 64'(out_reset), 64'd0);

        // Symbol pipeline
        run = 1'b1;
        top_symbols = 8'h41;
        tick();
        chk("sym_41", 64'(out_symbols), 64'h41);
        chk("out_run_1", 64'(out_run), 64'd1);
        top_symbols = 8'h42;
        tick();
        chk("sym_42", 64'(out_symbols), 64'h42);
        run = 1'b0;
        top_symbols = 8'h55;
        tick();
        chk("sym_hold", 64'(out_symbols), 64'h42);
        chk("out_run_0", 64'(out_run), 64'd0);

        // Single report at counter 3
        run = 1'b1;
        tick();
        rpt_ready = 1'b1;
        rpt_in = 40'd1 << 5;
        tick();
        run = 1'b0;
        rpt_in = '0;
        chk("single_valid", 64'(rpt_valid), 64'd1);
        chk("single_cycle", 64'(rpt_cycle), 64'd3);
        chk("single_vec", 64'(rpt_vec), 64'h20);
        tick();
        chk("single_drained", 64'(rpt_valid), 64'd0);
        chk("sticky_b5", 64'(rpt_sticky), 64'h20);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("sticky_clr", 64'(rpt_sticky), 64'd0);

        // Overfill: 20 reports into 16 entries
        rpt_ready = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rpt_in = 40'(i + 1) | (40'd1 << (i + 8));
            tick();
        end
        chk("ovf_set", 64'(rpt_overflow), 64'd1);
        chk("drop_4", 64'(rpt_drop_cnt), 64'd4);
        chk("sb_full", 64'(sbq.size()), 64'(DEPTH));

        // Full with pop and push together: nothing dropped
        rpt_ready = 1'b1;
        rpt_in = 40'hA5;
        tick();
        chk("full_pp_drop", 64'(rpt_drop_cnt), 64'd4);
        chk("full_pp_size", 64'(sbq.size()), 64'(DEPTH));

        // Drain everything in order
        run = 1'b0;
        rpt_in = '0;
        repeat (DEPTH) tick();
        chk("drained", 64'(rpt_valid), 64'd0);

        // Clear coincident with a new report bit 0
        run = 1'b1;
        rpt_in = 40'h1;
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        run = 1'b0;
        rpt_in = '0;
        chk("clr_sticky", 64'(rpt_sticky), 64'h1);
        chk("clr_ovf", 64'(rpt_overflow), 64'd0);
        chk("clr_drop", 64'(rpt_drop_cnt), 64'd0);
        tick();

        // Refill, then drop coincident with clear
        rpt_ready = 1'b0;
        run = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rpt_in = 40'(i + 3);
            tick();
        end
        rpt_in = 40'h80;
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        run = 1'b0;
        rpt_in = '0;
        chk("clrdrop_ovf", 64'(rpt_overflow), 64'd1);
        chk("clrdrop_cnt", 64'(rpt_drop_cnt), 64'd1);
        chk("clrdrop_sticky", 64'(rpt_sticky), 64'h80);

        // Drain to 5 entries, then reset
        rpt_ready = 1'b1;
        repeat (DEPTH - 5) tick();
        rpt_ready = 1'b0;
        chk("five_left", 64'(sbq.size()), 64'd5);
        reset = 1'b1;
        tick();
        chk("rst_valid", 64'(rpt_valid), 64'd0);
        chk("rst_out_reset", 64'(out_reset), 64'd1);
        chk("rst_sticky", 64'(rpt_sticky), 64'd0);
        chk("rst_drop", 64'(rpt_drop_cnt), 64'd0);
        reset = 1'b0;
        run = 1'b1;
        rpt_in = 40'h1;
        rpt_ready = 1'b1;
        tick();
        run = 1'b0;
        rpt_in = '0;
        chk("restart_cycle", 64'(rpt_cycle), 64'd0);
        tick();
        chk("end_empty", 64'(rpt_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
